// File: rtl/sim_uart_line_arbiter_if.sv
// rtl/sim_uart_line_arbiter_if.sv - byte source / UART sink bus bundle for sim_uart_line_arbiter
interface sim_uart_line_arbiter_if #(
  parameter int NCH = 3
);
  logic [NCH*8-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   overflow;
  logic [NCH-1:0]   overflow_clr;

  // Drives the byte sources, serializer ready and overflow clears.
  modport master (
    output in_data, in_valid, out_ready, overflow_clr,
    input  in_ready, out_data, out_valid, grant, overflow
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, out_ready, overflow_clr,
    output in_ready, out_data, out_valid, grant, overflow
  );
endinterface

// File: rtl/sim_uart_line_arbiter.sv
// rtl/sim_uart_line_arbiter.sv - line-atomic round-robin UART byte arbiter; optional SIM_UART_LINE_ARBITER_TAG_EN
module sim_uart_line_arbiter #(
  parameter int NCH        = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input logic                  clk,
  input logic                  resetn,
  sim_uart_line_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT);

`ifdef SIM_UART_LINE_ARBITER_TAG_EN
  typedef enum logic [1:0] {IDLE, SEND, TAG0, TAG1} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t          state;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   rr;
  logic [NCH-1:0]  grant_q;
  logic [TW-1:0]   tcnt;
  logic [NCH-1:0]  ovf_q;

  logic [7:0]      mem    [NCH][FIFO_DEPTH];
  logic [AW:0]     wr_ptr [NCH];
  logic [AW:0]     rd_ptr [NCH];

  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop_ch;
  logic            g_empty;
  logic [7:0]      head;
  logic            pop;
  logic            is_term;
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cidx;
  logic [7:0]      out_data_c;
  logic            out_valid_c;

  // FIFO status, pop/push strobes and the round-robin search starting after rr.
  always_comb begin
    empty   = '0;
    full    = '0;
    push    = '0;
    pop_ch  = '0;
    found   = 1'b0;
    sel     = '0;
    cidx    = '0;
    for (int i = 0; i < NCH; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      // Write acceptance ignores a same-cycle pop so in_ready stays a pure register decode.
      push[i]  = bus.in_valid[i] & ~full[i];
    end
    g_empty = empty[gidx];
    head    = mem[gidx][rd_ptr[gidx][AW-1:0]];
    pop     = (state == SEND) && !g_empty && bus.out_ready;
    is_term = (head == 8'h0A) || (head == 8'h0D);
    for (int i = 0; i < NCH; i++) begin
      pop_ch[i] = pop && (gidx == IW'(i));
    end
    for (int k = 1; k <= NCH; k++) begin
      cidx = IW'((int'(rr) + k) % NCH);
      if (!found && !empty[cidx]) begin
        found = 1'b1;
        sel   = cidx;
      end
    end
  end

  // Output byte mux: FIFO head while sending, prefix characters in the tag states.
  always_comb begin
    out_data_c  = 8'h00;
    out_valid_c = 1'b0;
    case (state)
      SEND: begin
        out_valid_c = !g_empty;
        out_data_c  = g_empty ? 8'h00 : head;
      end
`ifdef SIM_UART_LINE_ARBITER_TAG_EN
      TAG0: begin
        out_valid_c = 1'b1;
        out_data_c  = 8'h30 + 8'(gidx);
      end
      TAG1: begin
        out_valid_c = 1'b1;
        out_data_c  = 8'h3A;
      end
`endif
      default: begin
        out_valid_c = 1'b0;
        out_data_c  = 8'h00;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= bus.in_data[8*i +: 8];
      end
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i])   wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_ch[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~bus.overflow_clr) | (bus.in_valid & full);
    end
  end

  // Grant FSM: pick in IDLE, hold the line in SEND, release on CR/LF or idle timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      gidx    <= '0;
      grant_q <= '0;
      rr      <= IW'(NCH - 1);
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gidx    <= sel;
            grant_q <= NCH'(1) << sel;
            rr      <= sel;
            tcnt    <= '0;
`ifdef SIM_UART_LINE_ARBITER_TAG_EN
            state   <= TAG0;
`else
            state   <= SEND;
`endif
          end
        end
`ifdef SIM_UART_LINE_ARBITER_TAG_EN
        TAG0: begin
          if (bus.out_ready) state <= TAG1;
        end
        TAG1: begin
          if (bus.out_ready) begin
            state <= SEND;
            tcnt  <= '0;
          end
        end
`endif
        SEND: begin
          if (pop) begin
            tcnt <= '0;
            if (is_term) begin
              state   <= IDLE;
              grant_q <= '0;
            end
          end else if (g_empty) begin
            // Only an empty FIFO ages the line; backpressure never does.
            if (tcnt == TW'(TIMEOUT - 2)) begin
              state   <= IDLE;
              grant_q <= '0;
              tcnt    <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_data  = out_data_c;
  assign bus.out_valid = out_valid_c;
  assign bus.grant     = grant_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sim_uart_line_arbiter.sv
// tb/tb_sim_uart_line_arbiter.sv - randomized self-checking bench for sim_uart_line_arbiter
module tb_sim_uart_line_arbiter;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int TMO   = 12;
`ifdef SIM_UART_LINE_ARBITER_TAG_EN
  localparam bit TAGS = 1'b1;
`else
  localparam bit TAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sim_uart_line_arbiter_if #(.NCH(NCH)) bus();

  sim_uart_line_arbiter #(
    .NCH(NCH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: each channel is a byte queue, owner is the granted channel or -1.
  logic [7:0]     mq [NCH][$];
  int             m_own;
  int             m_phase;   // 0 = payload, 1 = first prefix char, 2 = second prefix char
  int             m_rr;
  int             m_idle;    // consecutive empty cycles on the current line
  logic [NCH-1:0] m_ovf;

  logic [7:0]     got_s [$];
  int             gseq [$];
  logic [NCH-1:0] last_grant;
  int             g0_empty;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_valid();
    if (m_own < 0) return 1'b0;
    if (m_phase != 0) return 1'b1;
    return mq[m_own].size() > 0;
  endfunction

  function automatic logic [7:0] m_data();
    if (m_phase == 1) return 8'h30 + 8'(m_own);
    if (m_phase == 2) return 8'h3A;
    return mq[m_own][0];
  endfunction

  function automatic logic [NCH-1:0] m_grant();
    if (m_own < 0) return '0;
    return NCH'(1) << m_own;
  endfunction

  function automatic logic [NCH-1:0] m_ready();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_own   = -1;
    m_phase = 0;
    m_rr    = NCH - 1;
    m_idle  = 0;
    m_ovf   = '0;
  endtask

  task automatic model_step(input logic [NCH-1:0] v, input logic [NCH*8-1:0] d,
                            input logic rdy, input logic [NCH-1:0] clr);
    int sz [NCH];
    logic [NCH-1:0] dropped;
    logic [7:0] b;
    dropped = '0;
    for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
    if (m_own < 0) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_rr + k) % NCH;
        if (sz[c] > 0) begin
          m_own   = c;
          m_rr    = c;
          m_idle  = 0;
          m_phase = TAGS ? 1 : 0;
          break;
        end
      end
    end else if (m_phase != 0) begin
      if (rdy) m_phase = (m_phase == 1) ? 2 : 0;
      m_idle = 0;
    end else if (sz[m_own] > 0) begin
      if (rdy) begin
        b = mq[m_own].pop_front();
        m_idle = 0;
        if (b == 8'h0A || b == 8'h0D) m_own = -1;
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO - 1) begin
        m_own  = -1;
        m_idle = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) begin
        if (sz[i] < DEPTH) mq[i].push_back(d[8*i +: 8]);
        else dropped[i] = 1'b1;
      end
    end
    m_ovf = (m_ovf & ~clr) | dropped;
  endtask

  task automatic compare_outputs();
    check_val("out_valid", bus.out_valid, m_valid());
    if (m_valid()) check_val("out_data", bus.out_data, m_data());
    check_val("grant", bus.grant, m_grant());
    check_val("in_ready", bus.in_ready, m_ready());
    check_val("overflow", bus.overflow, m_ovf);
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic [NCH*8-1:0] d,
                      input logic rdy, input logic [NCH-1:0] clr);
    @(negedge clk);
    compare_outputs();
    if (bus.grant == 3'b001 && !bus.out_valid) g0_empty++;
    if (bus.grant != '0 && bus.grant != last_grant) begin
      for (int i = 0; i < NCH; i++) if (bus.grant[i]) gseq.push_back(i);
    end
    last_grant       = bus.grant;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.out_ready    = rdy;
    bus.overflow_clr = clr;
    if (bus.out_valid && rdy) got_s.push_back(bus.out_data);
    model_step(v, d, rdy, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn           = 1'b0;
    bus.in_valid     = '0;
    bus.in_data      = '0;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = '0;
    #1;
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_out_data", bus.out_data, 8'h00);
    check_val("rst_grant", bus.grant, 3'b000);
    check_val("rst_in_ready", bus.in_ready, 3'b111);
    check_val("rst_overflow", bus.overflow, 3'b000);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    model_step('0, '0, 1'b0, '0);
    got_s.delete();
    gseq.delete();
    last_grant = '0;
    g0_empty   = 0;
  endtask

  task automatic send_lines(input string s0, input string s1, input string s2,
                            input int extra, input logic rdy);
    string s [NCH];
    string cur;
    int n;
    logic [NCH-1:0] v;
    logic [NCH*8-1:0] d;
    s[0] = s0; s[1] = s1; s[2] = s2;
    n = 0;
    for (int i = 0; i < NCH; i++) if (s[i].len() > n) n = s[i].len();
    for (int t = 0; t < n; t++) begin
      v = '0;
      d = '0;
      for (int i = 0; i < NCH; i++) begin
        cur = s[i];
        if (t < cur.len()) begin
          v[i]       = 1'b1;
          d[8*i +: 8] = cur[t];
        end
      end
      step(v, d, rdy, '0);
    end
    for (int t = 0; t < extra; t++) step('0, '0, rdy, '0);
  endtask

  task automatic check_stream(input string tag, input string exp);
    check_val({tag, "_len"}, got_s.size(), exp.len());
    for (int i = 0; i < exp.len() && i < got_s.size(); i++) begin
      check_val(tag, got_s[i], exp[i]);
    end
  endtask

  initial begin
    logic [NCH-1:0]   v;
    logic [NCH*8-1:0] d;
    logic [NCH-1:0]   clr;
    int               rdy_pct;
    bus.in_valid     = '0;
    bus.in_data      = '0;
    bus.out_ready    = 1'b0;
    bus.overflow_clr = '0;
    model_reset();
    do_reset();

    // Reset in the middle of a held line wipes the FIFO.
    send_lines("hello", "", "", 3, 1'b0);
    check_val("pre_rst_valid", bus.out_valid, 1'b1);
    do_reset();
    send_lines("", "", "", 20, 1'b1);
    check_val("stale_bytes", got_s.size(), 0);

    // Single line on channel 0.
    send_lines("AB\n", "", "", 20, 1'b1);
    check_stream("single_line", TAGS ? "0:AB\n" : "AB\n");

    // Two lines written on the same cycles never interleave.
    do_reset();
    send_lines("ab\n", "xy\n", "", 30, 1'b1);
    check_stream("two_lines", TAGS ? "0:ab\n1:xy\n" : "ab\nxy\n");

    // Round-robin order over repeated short lines.
    do_reset();
    send_lines("z\nz\n", "z\nz\n", "z\nz\n", 60, 1'b1);
    check_val("rr_count", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) check_val("rr_order", gseq[i], i % 3);

    // Overflow: 17 bytes into a stalled 16-deep FIFO.
    do_reset();
    send_lines("ABCDEFGHIJKLMNOPQ", "", "", 2, 1'b0);
    check_val("ovf_set", bus.overflow[0], 1'b1);
    check_val("ovf_full", bus.in_ready[0], 1'b0);
    step('0, '0, 1'b0, 3'b001);
    step('0, '0, 1'b0, 3'b000);
    check_val("ovf_clr", bus.overflow[0], 1'b0);
    send_lines("", "", "", 40, 1'b1);
    check_stream("ovf_drain", TAGS ? "0:ABCDEFGHIJKLMNOP" : "ABCDEFGHIJKLMNOP");

    // Unterminated line times out and yields to the waiting channel.
    do_reset();
    send_lines("abc", "q\n", "", 40, 1'b1);
    check_val("tmo_hold", g0_empty, TMO - 1);
    check_stream("tmo_stream", TAGS ? "0:abc1:q\n" : "abcq\n");

    // Random traffic against the model.
    do_reset();
    rdy_pct = 80;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 0) rdy_pct = $urandom_range(5, 100);
      v   = '0;
      d   = '0;
      clr = '0;
      for (int i = 0; i < NCH; i++) begin
        v[i] = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 3) == 0) d[8*i +: 8] = $urandom_range(0, 1) ? 8'h0A : 8'h0D;
        else d[8*i +: 8] = 8'h61 + 8'($urandom_range(0, 25));
        clr[i] = ($urandom_range(0, 9) == 0);
      end
      step(v, d, ($urandom_range(0, 99) < rdy_pct), clr);
    end
    send_lines("", "", "", 150, 1'b1);
    check_val("rand_drained", bus.grant, 3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
